// File: rtl/task_sorter.sv
// Priority task sorter: snapshots eight task lanes, scans them one per cycle, issues
// Execute for the best lane and supervises it. Optional lane aging: SORTER_AGING_EN.
module task_sorter #(
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [63:0] in_tasks,
   input  logic        sched_en,
   input  logic        exe_done,
   output logic [15:0] out_op,
   output logic        out_valid,
   output logic [3:0]  cur_id,
   output logic        busy,
   output logic        no_task
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_RUN    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   localparam logic [3:0] OPC_EXECUTE = 4'b0111;
   localparam logic [3:0] OPC_SUSPEND = 4'b0010;
   localparam logic [3:0] OPC_FINISH  = 4'b1111;

   state_t      state_r, state_s;
   logic [63:0] snap_r;
   logic [3:0]  scan_idx_r;
   logic        best_found_r;
   logic [3:0]  best_id_r;
   logic [3:0]  best_prio_r;
   logic [15:0] wd_r;
   logic        out_valid_s;
   logic        no_task_s;
   logic [15:0] out_op_s;
   logic [7:0]  lane_s;
   logic [3:0]  eff_prio_s;
   logic        take_s;

   // scan_idx_r 0..7 examines a lane; 8 is the decision cycle
   assign lane_s = snap_r[{scan_idx_r[2:0], 3'b000} +: 8];

`ifdef SORTER_AGING_EN
   logic [3:0] age_r [8];
   logic [2:0] best_lane_r;

   function automatic logic [3:0] aged_prio(input logic [3:0] prio, input logic [3:0] age);
      logic [4:0] sum;
      sum = {1'b0, prio} + {1'b0, age};
      return sum[4] ? 4'hF : sum[3:0];
   endfunction

   assign eff_prio_s = aged_prio(lane_s[3:0], age_r[scan_idx_r[2:0]]);
`else
   assign eff_prio_s = lane_s[3:0];
`endif

   // strictly greater wins, so ties keep the lower lane
   assign take_s = (scan_idx_r[3] == 1'b0) && (lane_s != 8'h00) &&
                   (!best_found_r || (eff_prio_s > best_prio_r));

   // Next-state and next-output decode
   always_comb begin
      state_s     = state_r;
      out_valid_s = 1'b0;
      out_op_s    = 16'h0000;
      no_task_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (sched_en) begin
               state_s = ST_SCAN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (!scan_idx_r[3]) begin
               state_s = ST_SCAN;
            end else if (best_found_r) begin
               state_s = ST_ISSUE;
            end else begin
               no_task_s = 1'b1;
               state_s   = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            out_valid_s = 1'b1;
            out_op_s    = {4'h0, cur_id, OPC_EXECUTE, 4'h0};
            state_s     = ST_RUN;
         end
         ST_RUN: begin
            if (exe_done) begin
               state_s = ST_FINISH;
            end else if (wd_r == (TIMEOUT - 16'd1)) begin
               out_valid_s = 1'b1;
               out_op_s    = {4'h0, cur_id, OPC_SUSPEND, 4'h0};
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FINISH: begin
            out_valid_s = 1'b1;
            out_op_s    = {4'h0, cur_id, OPC_FINISH, 4'h0};
            state_s     = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, registered outputs and scan/watchdog datapath
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r      <= ST_IDLE;
         out_op       <= 16'h0000;
         out_valid    <= 1'b0;
         no_task      <= 1'b0;
         busy         <= 1'b0;
         cur_id       <= 4'h0;
         snap_r       <= 64'h0;
         scan_idx_r   <= 4'h0;
         best_found_r <= 1'b0;
         best_id_r    <= 4'h0;
         best_prio_r  <= 4'h0;
         wd_r         <= 16'h0000;
`ifdef SORTER_AGING_EN
         best_lane_r  <= 3'd0;
`endif
      end else begin
         state_r   <= state_s;
         out_op    <= out_op_s;
         out_valid <= out_valid_s;
         no_task   <= no_task_s;
         busy      <= (state_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (sched_en) begin
                  snap_r       <= in_tasks;
                  scan_idx_r   <= 4'h0;
                  best_found_r <= 1'b0;
                  best_id_r    <= 4'h0;
                  best_prio_r  <= 4'h0;
               end
            end
            ST_SCAN: begin
               if (!scan_idx_r[3]) begin
                  scan_idx_r <= scan_idx_r + 4'd1;
                  if (take_s) begin
                     best_found_r <= 1'b1;
                     best_id_r    <= lane_s[7:4];
                     best_prio_r  <= eff_prio_s;
`ifdef SORTER_AGING_EN
                     best_lane_r  <= scan_idx_r[2:0];
`endif
                  end
               end else begin
                  cur_id <= best_found_r ? best_id_r : 4'h0;
               end
            end
            ST_ISSUE: begin
               wd_r <= 16'h0000;
            end
            ST_RUN: begin
               if (!exe_done && (wd_r != (TIMEOUT - 16'd1))) begin
                  wd_r <= wd_r + 16'd1;
               end else if (!exe_done) begin
                  cur_id <= 4'h0;
               end
            end
            ST_FINISH: begin
               cur_id <= 4'h0;
            end
            default: begin
               cur_id <= 4'h0;
            end
         endcase
      end
   end

`ifdef SORTER_AGING_EN
   // Age update at the decision cycle of a round that found a winner
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < 8; k++) begin
            age_r[k] <= 4'h0;
         end
      end else if ((state_r == ST_SCAN) && scan_idx_r[3] && best_found_r) begin
         for (int k = 0; k < 8; k++) begin
            if (3'(k) == best_lane_r) begin
               age_r[k] <= 4'h0;
            end else if ((snap_r[8*k +: 8] != 8'h00) && (age_r[k] != 4'hF)) begin
               age_r[k] <= age_r[k] + 4'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_task_sorter.sv
// Scoreboard bench for task_sorter: stimulus pushes predicted strobes, a negedge
// monitor pops and compares them (value and arrival cycle).
module tb_task_sorter;

   localparam logic [15:0] TO = 16'd20;

   logic        CLK = 1'b0;
   logic        RST;
   logic [63:0] in_tasks;
   logic        sched_en;
   logic        exe_done;
   logic [15:0] out_op;
   logic        out_valid;
   logic [3:0]  cur_id;
   logic        busy;
   logic        no_task;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      bit          nt;
      logic [15:0] op;
      int          at;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   age_m[8];

   task_sorter #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .in_tasks(in_tasks), .sched_en(sched_en),
      .exe_done(exe_done), .out_op(out_op), .out_valid(out_valid),
      .cur_id(cur_id), .busy(busy), .no_task(no_task)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: every strobe must match the head of the scoreboard
   always @(negedge CLK) begin
      if (RST === 1'b0) begin
         if (out_valid === 1'b1 || no_task === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {30'd0, out_valid, no_task}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("strobe_kind", {31'd0, no_task}, {31'd0, mon_e.nt});
               check("strobe_valid", {31'd0, out_valid}, {31'd0, ~mon_e.nt});
               check("strobe_cycle", cyc, mon_e.at);
               if (!mon_e.nt) check("out_op", {16'd0, out_op}, {16'd0, mon_e.op});
               if (!mon_e.nt && mon_e.op[7:4] == 4'h7)
                  check("cur_id_exec", {28'd0, cur_id}, {28'd0, mon_e.op[11:8]});
            end
         end else begin
            check("op_idle_zero", {16'd0, out_op}, 32'd0);
         end
      end
   end

   // reference: highest effective priority, first lane on ties
   task automatic predict(input logic [63:0] t, output bit found, output logic [3:0] id);
      int best_e;
      int best_k;
      logic [7:0] v;
      best_e = -1;
      best_k = 0;
      found  = 1'b0;
      id     = 4'h0;
      for (int k = 0; k < 8; k++) begin
         int e;
         v = t[8*k +: 8];
         if (v != 8'h00) begin
            e = int'(v[3:0]) + age_m[k];
            if (e > 15) e = 15;
            if (e > best_e) begin
               best_e = e;
               best_k = k;
            end
         end
      end
      if (best_e >= 0) begin
         found = 1'b1;
         v  = t[8*best_k +: 8];
         id = v[7:4];
`ifdef SORTER_AGING_EN
         for (int k = 0; k < 8; k++) begin
            if (k == best_k) age_m[k] = 0;
            else if (t[8*k +: 8] != 8'h00 && age_m[k] < 15) age_m[k] = age_m[k] + 1;
         end
`endif
      end
   endtask

   task automatic push(input bit nt, input logic [15:0] op, input int at);
      exp_t e;
      e.nt = nt;
      e.op = op;
      e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d strobes still pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge CLK);
   endtask

   // one scheduling round; d = cycles into RUN before exe_done (>19 means never)
   task automatic round(input logic [63:0] t, input int d, input bit scramble);
      int c;
      bit found;
      logic [3:0] id;
      @(negedge CLK);
      c = cyc;
      in_tasks = t;
      sched_en = 1'b1;
      predict(t, found, id);
      if (!found) begin
         push(1'b1, 16'h0000, c + 10);
      end else begin
         push(1'b0, {4'h0, id, 4'b0111, 4'h0}, c + 11);
         if (d <= 19) push(1'b0, {4'h0, id, 4'b1111, 4'h0}, c + 13 + d);
         else         push(1'b0, {4'h0, id, 4'b0010, 4'h0}, c + 31);
      end
      @(negedge CLK);
      sched_en = 1'b0;
      if (scramble) in_tasks = {$urandom, $urandom};
      if (found && d <= 19) begin
         while (cyc < c + 11 + d) @(negedge CLK);
         exe_done = 1'b1;
         @(negedge CLK);
         exe_done = 1'b0;
      end
      drain();
   endtask

   // start a round, then assert RST asynchronously after w further cycles
   task automatic abort_round(input logic [63:0] t, input int w);
      int c;
      bit found;
      logic [3:0] id;
      @(negedge CLK);
      c = cyc;
      in_tasks = t;
      sched_en = 1'b1;
      predict(t, found, id);
      if (w >= 10) push(1'b0, {4'h0, id, 4'b0111, 4'h0}, c + 11);
      @(negedge CLK);
      sched_en = 1'b0;
      repeat (w) @(negedge CLK);
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      #2 RST = 1'b1;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_op", {16'd0, out_op}, 32'd0);
      check("rst_cur_id", {28'd0, cur_id}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_no_task", {31'd0, no_task}, 32'd0);
      exp_q.delete();
      for (int k = 0; k < 8; k++) age_m[k] = 0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (25) @(negedge CLK);
      check("idle_after_abort", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      RST = 1'b1;
      in_tasks = 64'h0;
      sched_en = 1'b0;
      exe_done = 1'b0;
      for (int k = 0; k < 8; k++) age_m[k] = 0;
      repeat (3) @(negedge CLK);
      check("reset_out_op", {16'd0, out_op}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      check("post_reset_valid", {31'd0, out_valid}, 32'd0);
      check("post_reset_cur_id", {28'd0, cur_id}, 32'd0);
      check("post_reset_no_task", {31'd0, no_task}, 32'd0);

      round(64'h0000_0000_0035_2713, 3, 1'b1);   // id 2 via lane 1, op 0270
      round(64'h0000_0069_0000_4900, 2, 1'b0);   // tie: lane 1 id 4 beats lane 4
      round(64'h0000_0000_0000_0000, 0, 1'b1);   // no ready lane
      check("busy_after_no_task", {31'd0, busy}, 32'd0);
      round(64'h1000_0000_0000_0000, 25, 1'b0);  // prio 0 lane, watchdog suspend
      round(64'h0000_0000_0000_00A4, 19, 1'b0);  // exe_done on expiry cycle
      abort_round(64'h0000_0000_0000_5A3C, 4);   // reset inside SCAN
      abort_round(64'h0000_0000_0000_5A3C, 15);  // reset inside RUN
      for (int r = 0; r < 6; r++) round(64'h0000_0000_0000_2813, 1, 1'b0);

      for (int r = 0; r < 40; r++) begin
         logic [63:0] t;
         t = 64'h0;
         if ($urandom_range(7) != 0) begin
            for (int k = 0; k < 8; k++)
               if ($urandom_range(9) < 6) t[8*k +: 8] = 8'($urandom_range(255));
         end
         round(t, int'($urandom_range(23)), 1'b1);
      end

      check("queue_empty_at_end", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
